// File: rtl/four_to_one_mux_structural_pkg.sv
// Shared constants for the structural 4:1 mux: select codes ({S0,S1}, S0 is MSB)
// and the default data width.
package four_to_one_mux_structural_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/four_to_one_mux_structural_if.sv
// Select/data/result bundle of the structural 4:1 mux; the slave side is the mux.
interface four_to_one_mux_structural_if
    import four_to_one_mux_structural_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             S0;
    logic             S1;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Z;
    logic [WIDTH-1:0] Z_q;

    modport master (output S0, S1, A, B, C, D, input Z, Z_q);
    modport slave  (input S0, S1, A, B, C, D, output Z, Z_q);

endinterface

// File: rtl/four_to_one_mux_structural_mux2.sv
// Gate-level 2:1 mux, y = (d0 & ~s) | (d1 & s), replicated per bit with a shared select.
module mux2_gate #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    logic s_n;

    not u_inv (s_n, s);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic t0;
        logic t1;
        and u_and0 (t0, d0[i], s_n);
        and u_and1 (t1, d1[i], s);
        or  u_or   (y[i], t0, t1);
    end

endmodule

// File: rtl/four_to_one_mux_structural.sv
// Structural 4:1 mux: S1 picks within {A,B} and {C,D}, S0 picks between the pairs.
// Z is combinational; Z_q is its registered copy with asynchronous active-high reset.
module four_to_one_mux_structural
    import four_to_one_mux_structural_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    four_to_one_mux_structural_if.slave   bus
);
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] z_q;

    mux2_gate #(.WIDTH(WIDTH)) u_mux_ab (.d0(bus.A), .d1(bus.B), .s(bus.S1), .y(lo));
    mux2_gate #(.WIDTH(WIDTH)) u_mux_cd (.d0(bus.C), .d1(bus.D), .s(bus.S1), .y(hi));
    mux2_gate #(.WIDTH(WIDTH)) u_mux_out (.d0(lo), .d1(hi), .s(bus.S0), .y(z));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= '0;
        end else begin
            z_q <= z;
        end
    end

    assign bus.Z   = z;
    assign bus.Z_q = z_q;

endmodule

// File: tb/tb_four_to_one_mux_structural.sv
// Self-checking bench for four_to_one_mux_structural at WIDTH=1 and WIDTH=4.
module tb_four_to_one_mux_structural;
    import four_to_one_mux_structural_pkg::*;

    typedef struct {
        logic       z1;
        logic [3:0] z4;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    exp_t qz[$];
    exp_t qzq[$];
    exp_t e;
    exp_t prev;
    logic have_prev = 1'b0;
    logic sb_on     = 1'b0;

    four_to_one_mux_structural_if #(.WIDTH(1)) bus1 ();
    four_to_one_mux_structural_if #(.WIDTH(4)) bus4 ();

    four_to_one_mux_structural #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    four_to_one_mux_structural #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the select code simply indexes the four data words.
    function automatic logic [3:0] ref_sel(input logic [1:0] code, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] c,
                                           input logic [3:0] d);
        logic [3:0] vals [4];
        vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
        return vals[code];
    endfunction

    // Data bits for WIDTH=1 packed as {D,C,B,A}.
    task automatic drive1(input logic [1:0] code, input logic [3:0] dv);
        bus1.S0 = code[1];
        bus1.S1 = code[0];
        bus1.A  = dv[0];
        bus1.B  = dv[1];
        bus1.C  = dv[2];
        bus1.D  = dv[3];
    endtask

    task automatic drive4(input logic [1:0] code, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        bus4.S0 = code[1];
        bus4.S1 = code[0];
        bus4.A  = a;
        bus4.B  = b;
        bus4.C  = c;
        bus4.D  = d;
    endtask

    always @(negedge clk) begin
        if (sb_on) begin
            if (qz.size() > 0) begin
                e = qz.pop_front();
                chk("z_w1", {3'b0, bus1.Z}, {3'b0, e.z1});
                chk("z_w4", bus4.Z, e.z4);
            end
            if (have_prev) begin
                chk("zq_w1", {3'b0, bus1.Z_q}, {3'b0, prev.z1});
                chk("zq_w4", bus4.Z_q, prev.z4);
            end
            if (qzq.size() > 0) begin
                prev      = qzq.pop_front();
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] codes [4];
        logic [1:0] code;
        logic [3:0] dv;
        logic [5:0] v;
        logic [3:0] a4, b4, c4, d4;
        exp_t x;

        codes[0] = SEL_A; codes[1] = SEL_B; codes[2] = SEL_C; codes[3] = SEL_D;

        rst = 1'b1;
        drive1(SEL_A, 4'b0000);
        drive4(SEL_A, 4'h0, 4'h0, 4'h0, 4'h0);
        #1;
        chk("reset_zq_w1", {3'b0, bus1.Z_q}, 4'h0);
        chk("reset_zq_w4", bus4.Z_q, 4'h0);

        // Combinational checks run with reset held: Z must ignore rst and clk.
        for (int k = 0; k < 4; k++) begin
            code = codes[k];
            dv   = 4'b0001 << k;
            drive1(code, dv);
            #25;
            chk("directed_sel", {3'b0, bus1.Z}, 4'h1);
        end
        for (int k = 0; k < 4; k++) begin
            code = codes[k];
            dv   = ~(4'b0001 << k);
            drive1(code, dv);
            #25;
            chk("isolation", {3'b0, bus1.Z}, 4'h0);
        end
        chk("zq_held_in_reset", {3'b0, bus1.Z_q}, 4'h0);

        for (int i = 0; i < 64; i++) begin
            v    = i[5:0];
            code = v[5:4];
            dv   = v[3:0];
            drive1(code, dv);
            #2;
            chk("exhaustive", {3'b0, bus1.Z},
                ref_sel(code, {3'b0, dv[0]}, {3'b0, dv[1]}, {3'b0, dv[2]}, {3'b0, dv[3]}));
        end

        // Registered path: release reset, first edge captures D.
        @(negedge clk);
        drive1(SEL_D, 4'b1000);
        drive4(SEL_D, 4'hA, 4'h5, 4'h3, 4'hC);
        rst = 1'b0;
        #1;
        chk("zq_before_edge", {3'b0, bus1.Z_q}, 4'h0);
        @(posedge clk);
        #1;
        chk("zq_first_edge", {3'b0, bus1.Z_q}, 4'h1);
        chk("zq_first_edge_w4", bus4.Z_q, 4'hC);

        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_zq", {3'b0, bus1.Z_q}, 4'h0);
        chk("async_reset_zq_w4", bus4.Z_q, 4'h0);
        chk("async_reset_z", {3'b0, bus1.Z}, 4'h1);
        @(negedge clk);
        rst   = 1'b0;
        sb_on = 1'b1;

        // Clocked phase: directed WIDTH=4 sweep first, then random for both widths.
        for (int n = 0; n < 204; n++) begin
            @(posedge clk);
            #1;
            if (n < 4) begin
                code = codes[n];
                a4 = 4'hA; b4 = 4'h5; c4 = 4'h3; d4 = 4'hC;
            end else begin
                code = 2'($urandom_range(0, 3));
                a4 = 4'($urandom); b4 = 4'($urandom);
                c4 = 4'($urandom); d4 = 4'($urandom);
            end
            drive4(code, a4, b4, c4, d4);
            code = 2'($urandom_range(0, 3));
            dv   = 4'($urandom);
            drive1(code, dv);
            x.z1 = dv[code];
            x.z4 = ref_sel(bus4.S0 ? {1'b1, bus4.S1} : {1'b0, bus4.S1}, a4, b4, c4, d4);
            qz.push_back(x);
            qzq.push_back(x);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        sb_on = 1'b0;
        chk("drain_z", 4'(qz.size()), 4'h0);
        chk("drain_zq", 4'(qzq.size()), 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
